mips_avalon_bridge: RTL
=======================

Name: mips_avalon_bridge

Overview:
- Parametrised successor to the CPU-to-Avalon bus wrapper.
- Arbitrates two independent requesters (instruction channel, data channel) onto one Avalon-MM master port.
- Supports configurable data/address width, per-byte write enables and selectable arbitration policy.
- Uses explicit req/ack handshakes instead of clock gating, so a pipelined core, prefetcher or DMA can sit on either channel.

Parameters:
- ADDR_W, 32: address width of both channels and the bus.
- DATA_W, 32: data width; must be 32 or 64; BE_W = DATA_W/8.
- PRIORITY, 0: 0 = instruction first; 1 = data first; 2 = round-robin (last-granted channel loses ties).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction read request; held with i_addr until i_ack.
- i_addr  in  ADDR_W  instruction byte address.
- i_ack  out  1  one-cycle pulse; i_rdata valid this cycle.
- i_rdata  out  DATA_W  instruction word; held until the next i_ack.
- d_read  in  1  data read request.
- d_write  in  1  data write request; d_* fields stable until d_ack.
- d_addr  in  ADDR_W  data byte address.
- d_byteenable  in  BE_W  write/read lane enables.
- d_wdata  in  DATA_W  write data.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  DATA_W  read data; held until the next d_ack.
- stall  out  1  a request is pending and not yet acked.
- address  out  ADDR_W  Avalon address, word-aligned.
- read  out  1  Avalon read.
- write  out  1  Avalon write.
- byteenable  out  BE_W  Avalon byteenable.
- writedata  out  DATA_W  Avalon write data.
- waitrequest  in  1  Avalon stall.
- readdata  in  DATA_W  Avalon read data, valid the cycle after acceptance.

Behaviour:
- Reset (reset low, async): state IDLE; read, write, i_ack, d_ack = 0; address, byteenable, writedata, i_rdata, d_rdata = 0; round-robin pointer selects instruction.
- A reset assertion mid-transaction abandons the transaction; no ack is ever issued for it.
- FSM states:
  - IDLE: sample requests. If none, stay. If any, grant via PRIORITY and register the command into address/read/write/byteenable/writedata → CMD.
  - CMD: command held stable on the bus. At an edge with waitrequest=0 the command is accepted: write → ACK; read → RDATA. While waitrequest=1, stay (no limit).
  - RDATA: readdata registered into i_rdata or d_rdata for the granted channel → ACK.
  - ACK: the granted channel's ack is high for exactly this cycle; read/write are 0; → IDLE. Requests are not sampled in ACK.
- Requester rule: deassert, or present a new request, on the cycle after ack. A request still held in IDLE is treated as new.
- Latency:
  - Read with waitrequest=0: request at cycle 0 → ack at cycle 3.
  - Write with waitrequest=0: ack at cycle 2.
  - Each waitrequest cycle adds one cycle.
- Addressing and lanes:
  - address = {addr[ADDR_W-1:log2(BE_W)], zeros}.
  - Instruction reads drive byteenable all-ones.
  - Data transfers pass d_byteenable unmodified.
  - A data read with d_byteenable=0 is issued as all-ones.
- d_read and d_write both high: treated as a write.
- Arbitration:
  - Evaluated only in IDLE; a grant is never preempted.
  - Round-robin pointer flips on each ACK to the channel not just served.
  - A lone requester is always granted immediately, regardless of policy.
- stall = (i_req & ~i_ack) | ((d_read | d_write) & ~d_ack), combinational.
- At most one outstanding bus transaction; read and write are never high together.

Decomposition:
- Package mips_bus_pkg: state_t enum (IDLE, CMD, RDATA, ACK), channel_t (CH_INSTR, CH_DATA), PRIO_INSTR / PRIO_DATA / PRIO_RR constants.
- One sub-module, mips_bus_arbiter: 2-way combinational grant plus the round-robin pointer flop, parametrised by PRIORITY.

Test Plan:
- Instruction read, i_addr=0xBFC00003, waitrequest=0, readdata=0x24020005 → address=0xBFC00000, read=1 in cycle 1; i_ack in cycle 3 with i_rdata=0x24020005; byteenable=0xF.
- Data write, d_addr=0x1004, d_byteenable=0x3, d_wdata=0xDEADBEEF, waitrequest high 3 cycles → write held 4 cycles with address=0x1004, byteenable=0x3; d_ack exactly once, 1 cycle after acceptance.
- PRIORITY=0, i_req and d_read raised the same cycle → instruction served first, data second; two acks, no overlap.
- PRIORITY=2, both channels held continuously for 6 transactions → grants alternate I, D, I, D, I, D.
- Reset driven low during CMD of a read → read=0 immediately, no i_ack after release; a fresh request then completes normally.
- d_read and d_write both high, d_wdata=0x12345678 → bus write issued, read never asserted, d_ack once.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared types and policy constants for the MIPS-to-Avalon bus bridge.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RDATA,
        ACK
    } state_t;

    typedef enum logic {
        CH_INSTR,
        CH_DATA
    } channel_t;

    localparam int PRIO_INSTR = 0;
    localparam int PRIO_DATA  = 1;
    localparam int PRIO_RR    = 2;

endpackage

// File: rtl/mips_bus_arbiter.sv
// Two-way grant between the instruction and data channels, with a round-robin
// pointer that always favours the channel that was not served last.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int PRIORITY = PRIO_INSTR
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     i_req,
    input  logic     d_req,
    input  logic     served,
    input  channel_t served_ch,
    output logic     any_req,
    output channel_t grant
);

    channel_t rr_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= CH_INSTR;
        end else if (served) begin
            rr_ptr <= (served_ch == CH_INSTR) ? CH_DATA : CH_INSTR;
        end
    end

    // Policy only matters on a tie; a lone requester always wins.
    always_comb begin
        grant = CH_INSTR;
        if (i_req && d_req) begin
            case (PRIORITY)
                PRIO_DATA: grant = CH_DATA;
                PRIO_RR:   grant = rr_ptr;
                default:   grant = CH_INSTR;
            endcase
        end else if (d_req) begin
            grant = CH_DATA;
        end
    end

    assign any_req = i_req | d_req;

endmodule

// File: rtl/mips_avalon_bridge.sv
// Arbitrates an instruction and a data requester onto one Avalon-MM master,
// one outstanding transaction at a time, with req/ack handshakes on both sides.
module mips_avalon_bridge
    import mips_bus_pkg::*;
#(
    parameter  int ADDR_W   = 32,
    parameter  int DATA_W   = 32,
    parameter  int PRIORITY = PRIO_INSTR,
    localparam int BE_W     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [BE_W-1:0]   d_byteenable,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [BE_W-1:0]   byteenable,
    output logic [DATA_W-1:0] writedata,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BE_W - 1);
    localparam logic [BE_W-1:0]   BE_ALL     = '1;

    state_t   state, state_nx;
    channel_t gnt_ch, arb_grant;
    logic     any_req, d_req, served;

    assign d_req  = d_read | d_write;
    assign served = (state == ACK);

    mips_bus_arbiter #(.PRIORITY(PRIORITY)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .d_req     (d_req),
        .served    (served),
        .served_ch (gnt_ch),
        .any_req   (any_req),
        .grant     (arb_grant)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = CMD;
            CMD:     if (!waitrequest) state_nx = write ? ACK : RDATA;
            RDATA:   state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_ch     <= CH_INSTR;
            address    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= '0;
            writedata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    gnt_ch <= arb_grant;
                    if (arb_grant == CH_INSTR) begin
                        address    <= i_addr & ALIGN_MASK;
                        read       <= 1'b1;
                        write      <= 1'b0;
                        byteenable <= BE_ALL;
                    end else begin
                        // Write wins when both strobes are up; an empty read mask means a full word.
                        address    <= d_addr & ALIGN_MASK;
                        read       <= ~d_write;
                        write      <= d_write;
                        byteenable <= (!d_write && d_byteenable == '0) ? BE_ALL : d_byteenable;
                        writedata  <= d_wdata;
                    end
                end
                CMD: if (!waitrequest) begin
                    read  <= 1'b0;
                    write <= 1'b0;
                end
                RDATA: begin
                    if (gnt_ch == CH_INSTR) i_rdata <= readdata;
                    else                    d_rdata <= readdata;
                end
                default: ;
            endcase
        end
    end

    assign i_ack = served && (gnt_ch == CH_INSTR);
    assign d_ack = served && (gnt_ch == CH_DATA);
    assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

endmodule
